sr_ff_bist: RTL and testbench

Self-checking hardware driver for the SR flip-flop. On `start` it applies a fixed eight-vector S/R sequence to a flip-flop under test and samples `Q`/`Qb` after each vector. It compares the samples against an internal behavioural model and reports pass/fail, the first failing vector index and the total error count. It sits beside the flip-flop as a built-in self-test, so the flip-flop can be qualified in silicon or in any bench without a hand-written stimulus block.

---
 rtl/sr_ff_bist.sv | 149 ++++++++++++++
 tb/tb_sr_ff_bist.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bist.sv
// Built-in self-test driver for an SR flip-flop: plays an eight-vector S/R
// sequence, checks Q/Qb against a behavioural model, and reports the result.
module sr_ff_bist #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] sr_out,
  input  logic       q_in,
  input  logic       qb_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_idx,
  output logic [3:0] err_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [3:0] hold_cnt, hold_n;
  logic       exp_q, exp_n;
  logic       exp_valid, valid_n;
  logic       first_fail, ff_n;
  logic [3:0] err_n;
  logic [2:0] fidx_n;
  logic [1:0] cur_vec;
  logic       match;
  logic       drive_n;
  logic [1:0] sr_n;
  logic       busy_n, done_n, pass_n;

  // Stimulus ROM, {S, R}
  function automatic logic [1:0] vec_rom(input logic [2:0] i);
    case (i)
      3'd0:    vec_rom = 2'b10;
      3'd1:    vec_rom = 2'b00;
      3'd2:    vec_rom = 2'b01;
      3'd3:    vec_rom = 2'b00;
      3'd4:    vec_rom = 2'b10;
      3'd5:    vec_rom = 2'b11;
      3'd6:    vec_rom = 2'b01;
      default: vec_rom = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 3'd0;
      hold_cnt   <= 4'd0;
      exp_q      <= 1'b0;
      exp_valid  <= 1'b0;
      first_fail <= 1'b0;
      err_count  <= 4'd0;
      fail_idx   <= 3'd0;
      sr_out     <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      hold_cnt   <= hold_n;
      exp_q      <= exp_n;
      exp_valid  <= valid_n;
      first_fail <= ff_n;
      err_count  <= err_n;
      fail_idx   <= fidx_n;
      sr_out     <= sr_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    hold_n  = hold_cnt;
    exp_n   = exp_q;
    valid_n = exp_valid;
    ff_n    = first_fail;
    err_n   = err_count;
    fidx_n  = fail_idx;
    match   = 1'b0;
    cur_vec = vec_rom(idx);

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = DRIVE;
          idx_n   = 3'd0;
          hold_n  = 4'd0;
          valid_n = 1'b0;
          ff_n    = 1'b0;
          err_n   = 4'd0;
          fidx_n  = 3'd0;
        end
      end
      DRIVE: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_n  = 4'd0;
          state_n = CHECK;
        end else begin
          hold_n = hold_cnt + 4'd1;
        end
      end
      CHECK: begin
        case (cur_vec)
          2'b10: begin exp_n = 1'b1; valid_n = 1'b1; end
          2'b01: begin exp_n = 1'b0; valid_n = 1'b1; end
          2'b11: valid_n = 1'b0;
          default: ;
        endcase
        // An unknown Q/Qb leaves match low, so it is scored as a failure
        if (valid_n) begin
          if ((q_in == exp_n) && (qb_in == ~exp_n)) match = 1'b1;
          if (!match) begin
            err_n = err_count + 4'd1;
            if (!first_fail) begin
              fidx_n = idx;
              ff_n   = 1'b1;
            end
          end
        end
        if (idx == 3'd7) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + 3'd1;
          state_n = DRIVE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next-state view so they align with state
    drive_n = (state_n == DRIVE) || (state_n == CHECK);
    sr_n    = drive_n ? vec_rom(idx_n) : 2'b00;
    busy_n  = drive_n;
    done_n  = (state_n == DONE);
    pass_n  = done_n && (err_n == 4'd0);
  end

endmodule

// File: tb/tb_sr_ff_bist.sv
// Self-checking bench for sr_ff_bist: a behavioural SR flop with injectable
// faults feeds the BIST, and results are compared against a spec-level model.
module tb_sr_ff_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [1:0] sr_a, sr_b;
  logic       q_a, qb_a, q_b, qb_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [2:0] fidx_a, fidx_b;
  logic [3:0] err_a, err_b;

  int n_cmp = 0;
  int n_fail = 0;

  // Fault injection for instance a: 0 = healthy (+ per-vector flips), 1 = stuck Q=0, 2 = Qb tied to Q
  int         mode = 0;
  logic [7:0] fq = 8'h00, fqb = 8'h00;
  logic       ffa = 1'b0, ffb = 1'b0;
  int         cnt_a = 0;
  logic [2:0] ka;

  logic [1:0] vrom [8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};

  typedef struct {
    int         mode;
    logic [7:0] fq;
    logic [7:0] fqb;
    int         err;
    int         fidx;
    int         pass;
  } vec_t;

  sr_ff_bist #(.HOLD_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .sr_out(sr_a),
    .q_in(q_a), .qb_in(qb_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_idx(fidx_a), .err_count(err_a)
  );

  sr_ff_bist #(.HOLD_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .sr_out(sr_b),
    .q_in(q_b), .qb_in(qb_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_idx(fidx_b), .err_count(err_b)
  );

  always #5 clk = ~clk;

  // Behavioural SR flip-flops capturing the driven vector on each rising edge
  always @(posedge clk) begin
    case (sr_a)
      2'b10:   ffa <= 1'b1;
      2'b01:   ffa <= 1'b0;
      2'b11:   ffa <= 1'b0;
      default: ;
    endcase
    case (sr_b)
      2'b10:   ffb <= 1'b1;
      2'b01:   ffb <= 1'b0;
      2'b11:   ffb <= 1'b0;
      default: ;
    endcase
  end

  // Cycles since the start edge, used to know which vector a's flip mask applies to
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_a <= 0;
    else if (busy_a) cnt_a <= cnt_a + 1;
    else             cnt_a <= 0;
  end

  assign ka = 3'(cnt_a >> 1);

  always_comb begin
    q_a  = ffa ^ fq[ka];
    qb_a = ~ffa ^ fqb[ka];
    if (mode == 1) begin
      q_a  = 1'b0;
      qb_a = 1'b1;
    end else if (mode == 2) begin
      q_a  = ffa;
      qb_a = ffa;
    end
  end

  assign q_b  = ffb;
  assign qb_b = ~ffb;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: expected Q per vector and which vectors are scored
  function automatic void model(input int m, input logic [7:0] f1, input logic [7:0] f2,
                                output int e, output int fi);
    logic [7:0] expq = 8'b0001_0011;
    logic       q, qb;
    bit         found = 0;
    e  = 0;
    fi = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 5) continue;
      case (m)
        1:       begin q = 1'b0;     qb = 1'b1; end
        2:       begin q = expq[k];  qb = expq[k]; end
        default: begin q = expq[k] ^ f1[k]; qb = ~expq[k] ^ f2[k]; end
      endcase
      if (q != expq[k] || qb != ~expq[k]) begin
        e++;
        if (!found) begin
          fi    = k;
          found = 1;
        end
      end
    end
  endfunction

  // Pulses start on instance a and waits (bounded) for done; returns cycles from E0
  task automatic applyStimulus(input int m, input logic [7:0] f1, input logic [7:0] f2,
                               input bit mid_start, input bit seq_check, output int lat);
    int n = 0;
    mode = m;
    fq   = f1;
    fqb  = f2;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (!done_a && n < 200) begin
      if (seq_check && n < 16) begin
        checkOutput($sformatf("sr_out n=%0d", n), int'(sr_a), int'(vrom[n/2]));
        checkOutput($sformatf("busy n=%0d", n), int'(busy_a), 1);
      end
      start_a = mid_start && (n == 3);
      @(negedge clk);
      n++;
    end
    start_a = 1'b0;
    lat = n;
  endtask

  task automatic run_b(input bit from_done, output int lat);
    int n = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    if (from_done) begin
      checkOutput("b done drops on restart", int'(done_b), 0);
      checkOutput("b busy on restart", int'(busy_b), 1);
      checkOutput("b err cleared", int'(err_b), 0);
    end
    while (!done_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  initial begin
    vec_t tbl[6];
    int   lat, e, fi;

    tbl[0] = '{0, 8'h00, 8'h00, 0, 0, 1};
    tbl[1] = '{1, 8'h00, 8'h00, 3, 0, 0};
    tbl[2] = '{2, 8'h00, 8'h00, 7, 0, 0};
    tbl[3] = '{0, 8'h20, 8'h20, 0, 0, 1};
    tbl[4] = '{0, 8'h00, 8'h44, 2, 2, 0};
    tbl[5] = '{0, 8'h80, 8'h00, 1, 7, 0};

    repeat (3) @(negedge clk);
    checkOutput("reset sr_out", int'(sr_a), 0);
    checkOutput("reset busy", int'(busy_a), 0);
    checkOutput("reset done", int'(done_a), 0);
    checkOutput("reset pass", int'(pass_a), 0);
    checkOutput("reset fail_idx", int'(fidx_a), 0);
    checkOutput("reset err_count", int'(err_a), 0);
    checkOutput("reset b done", int'(done_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].mode, tbl[i].fq, tbl[i].fqb, 1'b0, i == 0, lat);
      checkOutput($sformatf("tbl%0d latency", i), lat, 16);
      checkOutput($sformatf("tbl%0d err_count", i), int'(err_a), tbl[i].err);
      checkOutput($sformatf("tbl%0d fail_idx", i), int'(fidx_a), tbl[i].fidx);
      checkOutput($sformatf("tbl%0d pass", i), int'(pass_a), tbl[i].pass);
      checkOutput($sformatf("tbl%0d busy", i), int'(busy_a), 0);
      checkOutput($sformatf("tbl%0d sr_out idle", i), int'(sr_a), 0);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("tbl%0d done held", i), int'(done_a), 1);
      checkOutput($sformatf("tbl%0d err held", i), int'(err_a), tbl[i].err);
    end

    // start pulsed mid-run must not restart or stretch the run
    applyStimulus(0, 8'h00, 8'h00, 1'b1, 1'b0, lat);
    checkOutput("mid-start latency", lat, 16);
    checkOutput("mid-start pass", int'(pass_a), 1);

    // Reset during idx 3 with a stuck DUT: partial errors must vanish
    mode = 1;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("pre-reset err_count", int'(err_a), 2);
    checkOutput("pre-reset sr_out idx3", int'(sr_a), 0);
    checkOutput("pre-reset busy", int'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset sr_out", int'(sr_a), 0);
    checkOutput("mid-reset busy", int'(busy_a), 0);
    checkOutput("mid-reset done", int'(done_a), 0);
    checkOutput("mid-reset err_count", int'(err_a), 0);
    checkOutput("mid-reset fail_idx", int'(fidx_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 8'h00, 8'h00, 1'b0, 1'b0, lat);
    checkOutput("post-reset latency", lat, 16);
    checkOutput("post-reset pass", int'(pass_a), 1);
    checkOutput("post-reset err_count", int'(err_a), 0);

    // HOLD_CYCLES = 3 instance: from IDLE, then restart from DONE
    run_b(1'b0, lat);
    checkOutput("b latency", lat, 32);
    checkOutput("b pass", int'(pass_b), 1);
    run_b(1'b1, lat);
    checkOutput("b restart latency", lat, 32);
    checkOutput("b restart pass", int'(pass_b), 1);

    // Randomized fault patterns against the reference model
    for (int r = 0; r < 20; r++) begin
      int         m;
      logic [7:0] f1, f2;
      m  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      f1 = 8'($urandom & $urandom);
      f2 = 8'($urandom & $urandom);
      model(m, f1, f2, e, fi);
      applyStimulus(m, f1, f2, 1'b0, 1'b0, lat);
      checkOutput($sformatf("rnd%0d latency", r), lat, 16);
      checkOutput($sformatf("rnd%0d err_count", r), int'(err_a), e);
      checkOutput($sformatf("rnd%0d fail_idx", r), int'(fidx_a), fi);
      checkOutput($sformatf("rnd%0d pass", r), int'(pass_a), (e == 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
